result_stream_serializer: RTL



---
 rtl/result_stream_serializer_pkg.sv | 29 ++
 rtl/result_stream_serializer_corr_round_packer.sv | 22 ++
 rtl/result_stream_serializer.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/result_stream_serializer_pkg.sv
// Shared constants for the decoder result stream: FSM states, header byte offsets
// and the correction-size formulas also used by the host receiver.
package result_stream_serializer_pkg;

   typedef enum logic [2:0] {IDLE, ITER, CYC_HI, CYC_LO, CORR, TRAIL} state_t;

   localparam int ITER_OFS   = 0;
   localparam int CYC_HI_OFS = 1;
   localparam int CYC_LO_OFS = 2;
   localparam int CORR_OFS   = 3;

   function automatic int ceil_div(input int a, input int b);
      return (a + b - 1) / b;
   endfunction

   // X-edges, Z-edges plus the boundary edge, and vertical edges of one round
   function automatic int corr_per_round(input int x, input int z);
      return (x - 1) * z + (x - 1) * z + 1 + x * z;
   endfunction

   function automatic int corr_bytes_per_round(input int x, input int z);
      return ceil_div(corr_per_round(x, z), 8);
   endfunction

   function automatic int num_rounds(input int u, input int contexts);
      return ceil_div(u, contexts) * contexts;
   endfunction

endpackage

// File: rtl/result_stream_serializer_corr_round_packer.sv
// Combinational packer: spreads the unpadded per-round correction bits onto
// byte-aligned round slots, zero-filling the tail of each round.
module corr_round_packer #(
   parameter int CORR_PER_ROUND       = 33,
   parameter int CORR_BYTES_PER_ROUND = 5,
   parameter int ROUNDS               = 5
) (
   input  logic [CORR_PER_ROUND*ROUNDS-1:0]         corrections,
   output logic [CORR_BYTES_PER_ROUND*8*ROUNDS-1:0] padded
);

   localparam int PADDED_W = CORR_BYTES_PER_ROUND * 8;

   // NOTE: default the whole vector first so the unwritten pad bits cannot infer a latch.
   always_comb begin
      padded = '0;
      for (int r = 0; r < ROUNDS; r++) begin
         padded[r*PADDED_W +: CORR_PER_ROUND] = corrections[r*CORR_PER_ROUND +: CORR_PER_ROUND];
      end
   end

endmodule

// File: rtl/result_stream_serializer.sv
// Snapshots one decode result and streams it as a fixed-length byte message.
// Define RESULT_TRAILER_EN to append an XOR checksum byte after the corrections.
module result_stream_serializer
   import result_stream_serializer_pkg::*;
#(
   parameter int GRID_WIDTH_X = 6,
   parameter int GRID_WIDTH_Z = 2,
   parameter int GRID_WIDTH_U = 5,
   parameter int NUM_CONTEXTS = 1,
   localparam int ROUNDS               = num_rounds(GRID_WIDTH_U, NUM_CONTEXTS),
   localparam int CORR_PER_ROUND       = corr_per_round(GRID_WIDTH_X, GRID_WIDTH_Z),
   localparam int CORR_BYTES_PER_ROUND = corr_bytes_per_round(GRID_WIDTH_X, GRID_WIDTH_Z)
) (
   input  logic                             clk,
   input  logic                             reset_n,
   input  logic                             result_valid,
   output logic                             result_ready,
   input  logic [7:0]                       iteration_count,
   input  logic [31:0]                      cycle_count,
   input  logic [CORR_PER_ROUND*ROUNDS-1:0] corrections,
   output logic [7:0]                       output_data,
   output logic                             output_valid,
   input  logic                             output_ready,
   output logic                             busy,
   output logic                             msg_done
);

   localparam int CORR_BYTES = CORR_BYTES_PER_ROUND * ROUNDS;
`ifdef RESULT_TRAILER_EN
   localparam int MSG_BYTES  = CORR_OFS + CORR_BYTES + 1;
`else
   localparam int MSG_BYTES  = CORR_OFS + CORR_BYTES;
`endif
   localparam int CNT_W  = ($clog2(MSG_BYTES) > 8) ? $clog2(MSG_BYTES) : 8;
   localparam int CIDX_W = (CORR_BYTES > 1) ? $clog2(CORR_BYTES) : 1;

   state_t                           state;
   logic [CNT_W-1:0]                 byte_cnt;
   logic [7:0]                       iter_q;
   logic [15:0]                      cyc_q;
   logic [CORR_PER_ROUND*ROUNDS-1:0] corr_q;
   logic [CORR_BYTES-1:0][7:0]       corr_bytes;
   logic [CNT_W-1:0]                 sel;
   logic [CIDX_W-1:0]                corr_idx;
   logic [7:0]                       next_byte;
`ifdef RESULT_TRAILER_EN
   logic [7:0]                       xor_q;
`endif

   corr_round_packer #(
      .CORR_PER_ROUND       (CORR_PER_ROUND),
      .CORR_BYTES_PER_ROUND (CORR_BYTES_PER_ROUND),
      .ROUNDS               (ROUNDS)
   ) u_packer (
      .corrections (corr_q),
      .padded      (corr_bytes)
   );

   // Byte to load next: the current index while nothing is presented yet, else the following one
   always_comb begin
      sel       = output_valid ? byte_cnt + CNT_W'(1) : byte_cnt;
      corr_idx  = CIDX_W'(sel - CNT_W'(CORR_OFS));
      next_byte = '0;
      if (sel == CNT_W'(ITER_OFS))
         next_byte = iter_q;
      else if (sel == CNT_W'(CYC_HI_OFS))
         next_byte = cyc_q[15:8];
      else if (sel == CNT_W'(CYC_LO_OFS))
         next_byte = cyc_q[7:0];
      else if (sel < CNT_W'(CORR_OFS + CORR_BYTES))
         next_byte = corr_bytes[corr_idx];
`ifdef RESULT_TRAILER_EN
      else
         next_byte = xor_q ^ output_data;
`endif
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         byte_cnt     <= '0;
         result_ready <= 1'b0;
         output_valid <= 1'b0;
         output_data  <= '0;
         busy         <= 1'b0;
         msg_done     <= 1'b0;
         // NOTE: snapshot registers are reset too, so nothing undefined can ever reach output_data.
         iter_q       <= '0;
         cyc_q        <= '0;
         corr_q       <= '0;
`ifdef RESULT_TRAILER_EN
         xor_q        <= '0;
`endif
      end else begin
         msg_done <= 1'b0;
         if (state == IDLE) begin
            result_ready <= 1'b1;
            if (result_valid && result_ready) begin
               iter_q       <= iteration_count;
               cyc_q        <= (cycle_count > 32'h0000_FFFF) ? 16'hFFFF : cycle_count[15:0];
               corr_q       <= corrections;
               state        <= ITER;
               byte_cnt     <= '0;
               busy         <= 1'b1;
               result_ready <= 1'b0;
`ifdef RESULT_TRAILER_EN
               xor_q        <= '0;
`endif
            end
         end else if (!output_valid) begin
            output_valid <= 1'b1;
            output_data  <= next_byte;
         end else if (output_ready) begin
`ifdef RESULT_TRAILER_EN
            xor_q <= xor_q ^ output_data;
`endif
            if (byte_cnt == CNT_W'(MSG_BYTES - 1)) begin
               state        <= IDLE;
               byte_cnt     <= '0;
               output_valid <= 1'b0;
               busy         <= 1'b0;
               msg_done     <= 1'b1;
               result_ready <= 1'b1;
            end else begin
               byte_cnt    <= byte_cnt + CNT_W'(1);
               output_data <= next_byte;
               case (state)
                  ITER:    state <= CYC_HI;
                  CYC_HI:  state <= CYC_LO;
                  CYC_LO:  state <= CORR;
`ifdef RESULT_TRAILER_EN
                  CORR:    if (byte_cnt == CNT_W'(MSG_BYTES - 2)) state <= TRAIL;
`endif
                  default: state <= state;
               endcase
            end
         end
      end
   end

endmodule
